dadd_pipe: RTL and testbench

Two-stage pipelined data adder for the blitter data path. It sits directly downstream of the adder-B operand mux. It takes four 16-bit A words and four 16-bit B words (source data or intensity/Z increments) and produces registered sums. Three arithmetic modes are supported: plain 16-bit, Gouraud intensity with saturation, and 32-bit Z with a carry chain. It uses a valid/ready handshake on both sides, so the blitter state machine can stall the write-back stage.

---
 rtl/dadd_pipe.sv | 140 ++++++++++++++
 tb/tb_dadd_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dadd_pipe.sv
// Two-stage pipelined 4x16-bit data adder for the blitter write-back path.
// Modes: plain wrapping add, saturating Gouraud intensity, and 32-bit Z with carry chain.
module dadd_pipe (
    input  logic        sys_clk,
    input  logic        resetl,
    input  logic [15:0] adda_0,
    input  logic [15:0] adda_1,
    input  logic [15:0] adda_2,
    input  logic [15:0] adda_3,
    input  logic [15:0] addb_0,
    input  logic [15:0] addb_1,
    input  logic [15:0] addb_2,
    input  logic [15:0] addb_3,
    input  logic [1:0]  daddmode,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] sum_0,
    output logic [15:0] sum_1,
    output logic [15:0] sum_2,
    output logic [15:0] sum_3,
    output logic [3:0]  sat,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [1:0] MODE_INT = 2'd1;
    localparam logic [1:0] MODE_Z   = 2'd2;

    // Unsigned 8.8 A plus signed B, clamped to [0, 0xFFFF]; returns {sat, sum}.
    // 18 bits are needed: the true range is -0x8000 .. 0x17FFE.
    function automatic logic [16:0] int_add(input logic [15:0] a, input logic [15:0] b);
        logic signed [17:0] s;
        s = $signed({2'b00, a}) + $signed({{2{b[15]}}, b});
        if (s < 18'sd0)
            int_add = {1'b1, 16'h0000};
        else if (s > 18'sd65535)
            int_add = {1'b1, 16'hFFFF};
        else
            int_add = {1'b0, s[15:0]};
    endfunction

    // Handshake: a side transfers when its valid and ready are both high at sys_clk.
    // S2 frees when empty or taken; S1 accepts when empty or moving into S2.
    logic s1_valid;
    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = in_valid && in_ready;

    logic [1:0]  s1_mode;
    logic [15:0] s1_sum0, s1_sum2;
    logic        s1_sat0, s1_sat2;
    logic        s1_c0, s1_c2;
    logic [15:0] s1_a1, s1_b1, s1_a3, s1_b3;

    // Stage 1 combinational: low words of each pair.
    logic [16:0] w0_raw, w2_raw, w0_int, w2_int;
    logic        in_is_int;

    always_comb begin
        in_is_int = (daddmode == MODE_INT);
        w0_raw    = {1'b0, adda_0} + {1'b0, addb_0};
        w2_raw    = {1'b0, adda_2} + {1'b0, addb_2};
        w0_int    = int_add(adda_0, addb_0);
        w2_int    = int_add(adda_2, addb_2);
    end

    // Stage 2 combinational: high words, carry taken from S1 only for Z beats.
    logic        s1_is_int;
    logic        cin1, cin3;
    logic [15:0] w1_wrap, w3_wrap;
    logic [16:0] w1_int, w3_int;

    always_comb begin
        s1_is_int = (s1_mode == MODE_INT);
        cin1      = (s1_mode == MODE_Z) && s1_c0;
        cin3      = (s1_mode == MODE_Z) && s1_c2;
        w1_wrap   = s1_a1 + s1_b1 + {15'd0, cin1};
        w3_wrap   = s1_a3 + s1_b3 + {15'd0, cin3};
        w1_int    = int_add(s1_a1, s1_b1);
        w3_int    = int_add(s1_a3, s1_b3);
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            s1_valid  <= 1'b0;
            s1_mode   <= 2'd0;
            s1_sum0   <= 16'h0000;
            s1_sum2   <= 16'h0000;
            s1_sat0   <= 1'b0;
            s1_sat2   <= 1'b0;
            s1_c0     <= 1'b0;
            s1_c2     <= 1'b0;
            s1_a1     <= 16'h0000;
            s1_b1     <= 16'h0000;
            s1_a3     <= 16'h0000;
            s1_b3     <= 16'h0000;
            out_valid <= 1'b0;
            sum_0     <= 16'h0000;
            sum_1     <= 16'h0000;
            sum_2     <= 16'h0000;
            sum_3     <= 16'h0000;
            sat       <= 4'h0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_mode  <= daddmode;
                s1_sum0  <= in_is_int ? w0_int[15:0] : w0_raw[15:0];
                s1_sum2  <= in_is_int ? w2_int[15:0] : w2_raw[15:0];
                s1_sat0  <= in_is_int && w0_int[16];
                s1_sat2  <= in_is_int && w2_int[16];
                s1_c0    <= w0_raw[16];
                s1_c2    <= w2_raw[16];
                s1_a1    <= adda_1;
                s1_b1    <= addb_1;
                s1_a3    <= adda_3;
                s1_b3    <= addb_3;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    sum_0 <= s1_sum0;
                    sum_2 <= s1_sum2;
                    sum_1 <= s1_is_int ? w1_int[15:0] : w1_wrap;
                    sum_3 <= s1_is_int ? w3_int[15:0] : w3_wrap;
                    sat   <= {s1_is_int && w3_int[16], s1_sat2,
                              s1_is_int && w1_int[16], s1_sat0};
                end
            end
        end
    end

endmodule

// File: tb/tb_dadd_pipe.sv
// Directed bench for dadd_pipe: driver pushes hand-computed results into a queue,
// a negedge monitor pops and compares on every output transfer.
module tb_dadd_pipe;

    logic        sys_clk;
    logic        resetl;
    logic [15:0] adda_0, adda_1, adda_2, adda_3;
    logic [15:0] addb_0, addb_1, addb_2, addb_3;
    logic [1:0]  daddmode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sum_0, sum_1, sum_2, sum_3;
    logic [3:0]  sat;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    logic [67:0] exp_q[$];

    dadd_pipe dut (
        .sys_clk  (sys_clk),
        .resetl   (resetl),
        .adda_0   (adda_0),
        .adda_1   (adda_1),
        .adda_2   (adda_2),
        .adda_3   (adda_3),
        .addb_0   (addb_0),
        .addb_1   (addb_1),
        .addb_2   (addb_2),
        .addb_3   (addb_3),
        .daddmode (daddmode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum_0    (sum_0),
        .sum_1    (sum_1),
        .sum_2    (sum_2),
        .sum_3    (sum_3),
        .sat      (sat),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // Clock and watchdog
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Drive one beat; expected {sat, sum_3, sum_2, sum_1, sum_0} is queued when it is accepted.
    task automatic send(input logic [1:0] m,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] a2, input logic [15:0] a3,
                        input logic [15:0] b0, input logic [15:0] b1,
                        input logic [15:0] b2, input logic [15:0] b3,
                        input logic [63:0] es, input logic [3:0] esat);
        bit ok;
        ok = 1'b0;
        daddmode = m;
        adda_0 = a0; adda_1 = a1; adda_2 = a2; adda_3 = a3;
        addb_0 = b0; addb_1 = b1; addb_2 = b2; addb_3 = b3;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge sys_clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                exp_q.push_back({esat, es});
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required 1");
        end
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge sys_clk) begin
        if (resetl && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h, required no output",
                         {sat, sum_3, sum_2, sum_1, sum_0});
            end else begin
                check("output", {sat, sum_3, sum_2, sum_1, sum_0}, exp_q.pop_front());
            end
        end
    end

    initial begin
        resetl = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        daddmode = 2'd0;
        adda_0 = '0; adda_1 = '0; adda_2 = '0; adda_3 = '0;
        addb_0 = '0; addb_1 = '0; addb_2 = '0; addb_3 = '0;
        repeat (3) @(posedge sys_clk);
        #1 resetl = 1'b1;
        @(negedge sys_clk);
        check("reset_state", {61'd0, out_valid, sat, in_ready, 2'd0},
              {61'd0, 1'b0, 4'h0, 1'b1, 2'd0});
        check("reset_sums", {4'h0, sum_3, sum_2, sum_1, sum_0}, 68'd0);
        @(posedge sys_clk);
        #1;

        // Mode 0 wrap, mode 2 carry, mode 1 saturation, reserved mode 3
        send(2'd0, 16'hFFFF, 16'h1234, 16'h0003, 16'h8000,
                   16'h0001, 16'h0000, 16'h0004, 16'h8000,
             {16'h0000, 16'h0007, 16'h1234, 16'h0000}, 4'b0000);
        send(2'd2, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h7FFF,
                   16'h0001, 16'h0000, 16'h0001, 16'h0000,
             {16'h8000, 16'h0000, 16'h0001, 16'h0000}, 4'b0000);
        send(2'd1, 16'hFF80, 16'h0080, 16'h1000, 16'hFFFF,
                   16'h0100, 16'hFF00, 16'h0010, 16'hFFFF,
             {16'hFFFE, 16'h1010, 16'h0000, 16'hFFFF}, 4'b0011);
        send(2'd1, 16'h0000, 16'hFFFF, 16'h0100, 16'h0000,
                   16'h8000, 16'h7FFF, 16'hFF00, 16'h0001,
             {16'h0001, 16'h0000, 16'hFFFF, 16'h0000}, 4'b0011);
        send(2'd3, 16'hFFFF, 16'h0001, 16'h0000, 16'hABCD,
                   16'h0002, 16'h0001, 16'h0000, 16'h1111,
             {16'hBCDE, 16'h0000, 16'h0002, 16'h0001}, 4'b0000);
        send(2'd2, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h1234,
                   16'h0001, 16'h0000, 16'h8000, 16'h0001,
             {16'h1236, 16'h0000, 16'h0000, 16'h0000}, 4'b0000);

        // Mixed modes back-to-back: carry reaches sum_1 only on Z beats
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                send(2'd2, 16'hFFFF, 16'h0010, 16'h0000, 16'h0000,
                           16'h0001, 16'h0020, 16'h0000, 16'h0000,
                     {16'h0000, 16'h0000, 16'h0031, 16'h0000}, 4'b0000);
            else
                send(2'd0, 16'hFFFF, 16'h0010, 16'h0000, 16'h0000,
                           16'h0001, 16'h0020, 16'h0000, 16'h0000,
                     {16'h0000, 16'h0000, 16'h0030, 16'h0000}, 4'b0000);
        end
        repeat (3) @(posedge sys_clk);
        #1;

        // Backpressure: A and B fill the pipe, C waits
        out_ready = 1'b0;
        send(2'd0, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
                   16'h0010, 16'h0020, 16'h0030, 16'h0040,
             {16'h0044, 16'h0033, 16'h0022, 16'h0011}, 4'b0000);
        send(2'd0, 16'h0100, 16'h0200, 16'h0300, 16'h0400,
                   16'h0001, 16'h0001, 16'h0001, 16'h0001,
             {16'h0401, 16'h0301, 16'h0201, 16'h0101}, 4'b0000);
        daddmode = 2'd2;
        adda_0 = 16'hFFFF; adda_1 = 16'h0001; adda_2 = 16'h0000; adda_3 = 16'h0000;
        addb_0 = 16'h0001; addb_1 = 16'h0001; addb_2 = 16'h0000; addb_3 = 16'h0000;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("stall_in_ready", {67'd0, in_ready}, 68'd0);
            check("stall_hold", {out_valid, sat[2:0], sum_3, sum_2, sum_1, sum_0},
                  {1'b1, 3'b000, 16'h0044, 16'h0033, 16'h0022, 16'h0011});
        end
        @(posedge sys_clk);
        #1 out_ready = 1'b1;
        send(2'd2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000,
                   16'h0001, 16'h0001, 16'h0000, 16'h0000,
             {16'h0000, 16'h0000, 16'h0003, 16'h0000}, 4'b0000);
        repeat (4) @(posedge sys_clk);
        #1;

        // Reset while two beats are stalled inside
        out_ready = 1'b0;
        send(2'd0, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                   16'h0001, 16'h0001, 16'h0001, 16'h0001,
             {16'h4445, 16'h3334, 16'h2223, 16'h1112}, 4'b0000);
        send(2'd0, 16'h5555, 16'h6666, 16'h7777, 16'h8888,
                   16'h0001, 16'h0001, 16'h0001, 16'h0001,
             {16'h8889, 16'h7778, 16'h6667, 16'h5556}, 4'b0000);
        resetl = 1'b0;
        @(posedge sys_clk);
        #1 resetl = 1'b1;
        exp_q.delete();
        @(negedge sys_clk);
        check("midreset_state", {61'd0, out_valid, sat, in_ready, 2'd0},
              {61'd0, 1'b0, 4'h0, 1'b1, 2'd0});
        check("midreset_sums", {4'h0, sum_3, sum_2, sum_1, sum_0}, 68'd0);
        @(posedge sys_clk);
        #1 out_ready = 1'b1;
        send(2'd0, 16'h0005, 16'h0006, 16'h0007, 16'h0008,
                   16'h0001, 16'h0001, 16'h0001, 16'h0001,
             {16'h0009, 16'h0008, 16'h0007, 16'h0006}, 4'b0000);

        // Drain, then idle a few cycles so any stray output is caught
        for (int t = 0; t < 50; t++) begin
            if (exp_q.size() == 0) break;
            @(negedge sys_clk);
        end
        check("drain_empty", 68'(exp_q.size()), 68'd0);
        repeat (5) @(negedge sys_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
